// File: rtl/y_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package y_serial_pkg;

  localparam int SUB_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/y_serial_sub_fa.sv
// Single-bit full adder; the serial datapath's only arithmetic element.
module y_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/y_serial_sub.sv
// Bit-serial signed subtractor: z = a - b - bin, one bit per clock, LSB first,
// computed as a + ~b + ~bin through one full adder and a carry register.
module y_serial_sub
  import y_serial_pkg::*;
#(
  parameter int W = SUB_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = cnt_width(W);

  state_e        state;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  res;
  logic [CW-1:0] cnt;
  logic          c;
  logic          a_msb;
  logic          b_msb;
  logic          fa_s;
  logic          fa_cout;

  y_full_adder u_fa (
    .a    (sa[0]),
    .b    (~sb[0]),
    .cin  (c),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // NOTE: the operand/result shift registers are plain flops, so they are
  // reset with everything else; a mid-run reset must leave no stale partial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      c     <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge values
      // (e.g. the DONE flags see res/c exactly as the last RUN edge left them).
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            c     <= ~bin;
            cnt   <= '0;
            a_msb <= a[W-1];
            b_msb <= b[W-1];
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res <= {fa_s, res[W-1:1]};
          sa  <= {1'b0, sa[W-1:1]};
          sb  <= {1'b0, sb[W-1:1]};
          c   <= fa_cout;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          z     <= res;
          bout  <= ~c;
          // Overflow only possible when operand signs differ.
          ovf   <= (a_msb != b_msb) && (res[W-1] != a_msb);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
